mux_n_1_rr: RTL and testbench

Parametrised N-to-1 registered channel multiplexer, the successor to the 4:1 single-bit combinational mux.
- Selects one of N_CH DATA_W-bit input channels with per-channel valid/ready handshake.
- Two selection modes: fixed (external select) or round-robin arbitration.
- Result lands in a one-entry output register with valid/ready toward the consumer.
- Sits between multiple producers and a single shared downstream datapath.

---
 rtl/mux_n_1_rr_pkg.sv | 13 +
 rtl/mux_n_1_rr_if.sv | 40 ++++
 rtl/mux_n_1_rr_rr_arbiter.sv | 33 +++
 rtl/mux_n_1_rr.sv | 126 ++++++++++++
 tb/tb_mux_n_1_rr.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mux_n_1_rr_pkg.sv
// rtl/mux_n_1_rr_pkg.sv - shared constants and index helper for mux_n_1_rr
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   CNT_W      = 16;

  // idx is at most 2*n-1, so a single conditional subtract wraps it without a modulo
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mux_n_1_rr_if.sv
// rtl/mux_n_1_rr_if.sv - producer/consumer bus of mux_n_1_rr; Grant_cnt present under MUX_STATS_EN
interface mux_n_1_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
);
  import mux_pkg::*;

  logic [N_CH*DATA_W-1:0] In_data;
  logic [N_CH-1:0]        In_valid;
  logic [N_CH-1:0]        In_ready;
  logic                   Mode;
  logic [SEL_W-1:0]       Sel;
  logic [DATA_W-1:0]      Out_data;
  logic [SEL_W-1:0]       Out_ch;
  logic                   Out_valid;
  logic                   Out_ready;
`ifdef MUX_STATS_EN
  logic [N_CH*CNT_W-1:0]  Grant_cnt;

  modport slave (
    input  In_data, In_valid, Mode, Sel, Out_ready,
    output In_ready, Out_data, Out_ch, Out_valid, Grant_cnt
  );
  modport master (
    output In_data, In_valid, Mode, Sel, Out_ready,
    input  In_ready, Out_data, Out_ch, Out_valid, Grant_cnt
  );
`else
  modport slave (
    input  In_data, In_valid, Mode, Sel, Out_ready,
    output In_ready, Out_data, Out_ch, Out_valid
  );
  modport master (
    output In_data, In_valid, Mode, Sel, Out_ready,
    input  In_ready, Out_data, Out_ch, Out_valid
  );
`endif

endinterface

// File: rtl/mux_n_1_rr_rr_arbiter.sv
// rtl/mux_n_1_rr_rr_arbiter.sv - round-robin search starting one past the last winner
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  int               idx;
  logic [SEL_W-1:0] idx_s;

  // The last winner is visited last (i == N_CH), giving it lowest priority
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    idx_s       = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx   = wrap_idx(int'(ptr) + i, N_CH);
      idx_s = SEL_W'(idx);
      if (!grant_valid && req[idx_s]) begin
        grant       = idx_s;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_1_rr.sv
// rtl/mux_n_1_rr.sv - N:1 registered channel mux, fixed or round-robin select
// Optional per-channel grant counters under MUX_STATS_EN.
module mux_n_1_rr
  import mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic          Clk,
  input  logic          Rst,
  mux_n_1_rr_if.slave   bus
);

  localparam int PAD_W = 1 << SEL_W;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]  ptr_q,       ptr_d;

  logic              load_en;
  logic              xfer;
  logic [SEL_W-1:0]  rr_grant;
  logic              rr_valid;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic [PAD_W-1:0]  valid_pad;
  logic [N_CH-1:0]   in_ready;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_arbiter (
    .req         (bus.In_valid),
    .ptr         (ptr_q),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // valid_pad lets an out-of-range Sel index safely; the range test kills the grant
  always_comb begin
    valid_pad = PAD_W'(bus.In_valid);
    load_en   = !out_valid_q || bus.Out_ready;
    if (bus.Mode == MODE_RR) begin
      grant       = rr_grant;
      grant_valid = rr_valid;
    end else begin
      grant       = bus.Sel;
      grant_valid = (int'(bus.Sel) < N_CH) && valid_pad[bus.Sel];
    end
    xfer     = load_en && grant_valid && !Rst;
    in_ready = xfer ? (N_CH'(1) << grant) : '0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.In_data[int'(grant)*DATA_W +: DATA_W];
      out_ch_d    = grant;
      if (bus.Mode == MODE_RR) begin
        ptr_d = grant;
      end
    end else if (out_valid_q && bus.Out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= SEL_W'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_data  = out_data_q;
  assign bus.Out_ch    = out_ch_q;
  assign bus.Out_valid = out_valid_q;

`ifdef MUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH*CNT_W-1:0] cnt_flat;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      cnt_d[k] = cnt_q[k];
      if (in_ready[k] && bus.In_valid[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (Rst) begin
        cnt_q[k] <= '0;
      end else begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int k = 0; k < N_CH; k++) begin
      cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  assign bus.Grant_cnt = cnt_flat;
`endif

endmodule

// File: tb/tb_mux_n_1_rr.sv
// tb/tb_mux_n_1_rr.sv - scoreboard bench for mux_n_1_rr against a behavioural model
module tb_mux_n_1_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  mux_n_1_rr_if #(.N_CH(N), .DATA_W(W)) b ();
  mux_n_1_rr_if #(.N_CH(3), .DATA_W(W)) b3 ();

  mux_n_1_rr #(.N_CH(N), .DATA_W(W)) dut (.Clk(clk), .Rst(rst), .bus(b.slave));
  mux_n_1_rr #(.N_CH(3), .DATA_W(W)) dut3 (.Clk(clk), .Rst(rst3), .bus(b3.slave));

  typedef struct {
    logic [W-1:0] d;
    int           ch;
  } item_t;

  item_t sb[$];
  int    ch_log[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  bit    m_valid;
  int    m_ptr;
  int    m_cnt [N];
  bit    oor_chk = 0;
  bit    exp_v3  = 0;
  logic [W-1:0] hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fixed picks Sel if legal; RR picks first valid scanning after the last winner
  function automatic void model_grant(input logic mode, input int sel, input logic [N-1:0] v,
                                      output int g, output bit ok);
    g  = 0;
    ok = 0;
    if (mode == 1'b0) begin
      if (sel < N && v[sel]) begin
        g  = sel;
        ok = 1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!ok && v[c]) begin
          g  = c;
          ok = 1;
        end
      end
    end
  endfunction

  task automatic model_eval();
    int   g;
    bit   ok;
    bit   load;
    logic [N-1:0] exp_r;
    if (rst) begin
      chk("in_ready_rst", 32'(b.In_ready), 0);
      m_valid = 0;
      m_ptr   = N - 1;
      sb.delete();
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      chk("out_valid", 32'(b.Out_valid), 32'(m_valid));
      model_grant(b.Mode, int'(b.Sel), b.In_valid, g, ok);
      load  = !m_valid || b.Out_ready;
      exp_r = (load && ok) ? (N'(1) << g) : '0;
      chk("in_ready", 32'(b.In_ready), 32'(exp_r));
      if (load && ok) begin
        sb.push_back('{d: b.In_data[g*W +: W], ch: g});
        if (b.Mode) m_ptr = g;
        m_cnt[g]++;
        m_valid = 1;
      end else if (m_valid && b.Out_ready) begin
        m_valid = 0;
      end
    end
    if (oor_chk) begin
      chk("oor_in_ready", 32'(b3.In_ready), 0);
      chk("oor_out_valid", 32'(b3.Out_valid), 32'(exp_v3));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each word the consumer takes must be the oldest expected word
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst && b.Out_valid && b.Out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          it = sb.pop_front();
          chk("out_data", 32'(b.Out_data), 32'(it.d));
          chk("out_ch", 32'(b.Out_ch), 32'(it.ch));
        end
        ch_log.push_back(int'(b.Out_ch));
      end
    end
  end

  task automatic do_reset();
    rst         = 1;
    b.Out_ready = 0;
    b.In_valid  = '1;
    repeat (2) cycle();
    chk("rst_out_valid", 32'(b.Out_valid), 0);
    chk("rst_out_data", 32'(b.Out_data), 0);
    chk("rst_out_ch", 32'(b.Out_ch), 0);
    rst = 0;
    b.In_valid = '0;
    ch_log.delete();
  endtask

  task automatic check_log(input string name, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int len);
    int exp_seq [5];
    exp_seq = '{e0, e1, e2, e3, e4};
    chk({name, "_len"}, 32'(ch_log.size()), 32'(len));
    for (int i = 0; i < len && i < ch_log.size(); i++) chk(name, 32'(ch_log[i]), 32'(exp_seq[i]));
    ch_log.delete();
  endtask

  initial begin
    rst = 1; rst3 = 1;
    b.In_data = '0; b.In_valid = '0; b.Mode = 1'b1; b.Sel = '0; b.Out_ready = 0;
    b3.In_data = '0; b3.In_valid = '0; b3.Mode = 1'b0; b3.Sel = '0; b3.Out_ready = 1;
    m_valid = 0; m_ptr = N - 1;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    #1;
    do_reset();

    // Round-robin fairness from reset: channel 0 first
    b.Mode = 1; b.Out_ready = 1; b.In_valid = 4'b1111;
    repeat (5) begin b.In_data = $urandom; cycle(); end
    b.In_valid = '0;
    repeat (2) cycle();
    check_log("rr_all", 0, 1, 2, 3, 0, 5);
    b.In_valid = 4'b1010;
    repeat (4) begin b.In_data = $urandom; cycle(); end
    b.In_valid = '0;
    repeat (2) cycle();
    check_log("rr_1010", 1, 3, 1, 3, 0, 4);

    // Fixed select of channel 2
    b.Mode = 0; b.Sel = 2; b.In_valid = 4'b1111; b.In_data = 32'h43322110;
    repeat (4) cycle();
    chk("fixed_data", 32'(b.Out_data), 32'h32);
    b.In_valid = '0;
    repeat (2) cycle();
    check_log("fixed", 2, 2, 2, 2, 0, 4);

    // Backpressure: held word stays put while inputs churn
    b.Mode = 1; b.In_valid = 4'b1111; b.In_data = $urandom;
    cycle();
    b.Out_ready = 0;
    hold = b.Out_data;
    repeat (5) begin b.In_data = $urandom; cycle(); chk("bp_hold", 32'(b.Out_data), 32'(hold)); end
    b.Out_ready = 1;
    repeat (2) begin b.In_data = $urandom; cycle(); end
    b.In_valid = '0;
    repeat (2) cycle();

    // Random traffic with a reset landing mid-stream
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        b.In_valid = '1; b.In_data = $urandom; b.Mode = 1; b.Out_ready = 0;
        cycle();
        do_reset();
      end
      b.Mode      = $urandom_range(0, 1);
      b.Sel       = 2'($urandom_range(0, N - 1));
      b.In_valid  = 4'($urandom);
      b.In_data   = $urandom;
      b.Out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    b.In_valid = '0; b.Out_ready = 1;
    repeat (3) cycle();
    chk("sb_empty", 32'(sb.size()), 0);

    // Three-channel instance: Sel=3 is out of range and must never grant
    rst3 = 0;
    b3.Sel = 0; b3.In_valid = 3'b111; b3.In_data = 24'hC3B2A1; b3.Out_ready = 1;
    cycle();
    b3.Sel = 2'd3;
    oor_chk = 1; exp_v3 = 1;
    cycle();
    chk("oor_data", 32'(b3.Out_data), 32'hA1);
    exp_v3 = 0;
    repeat (4) cycle();
    oor_chk = 0;

`ifdef MUX_STATS_EN
    for (int k = 0; k < N; k++)
      chk("grant_cnt", 32'(b.Grant_cnt[k*16 +: 16]), 32'(m_cnt[k] > 16'hFFFF ? 16'hFFFF : m_cnt[k]));
    b.Mode = 0; b.Sel = 1; b.In_valid = 4'b0010; b.Out_ready = 1;
    repeat (70000) begin b.In_data = $urandom; cycle(); end
    b.In_valid = '0;
    repeat (2) cycle();
    chk("grant_cnt_sat", 32'(b.Grant_cnt[16 +: 16]), 32'hFFFF);
    do_reset();
    chk("grant_cnt_clr", 32'(b.Grant_cnt == '0), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
